fetch_ifid_unit: RTL and testbench
==================================

Name: fetch_ifid_unit

Overview:
- Instruction-fetch stage directly downstream of the program counter.
- Drives the instruction-memory read address from the current PC and assembles 16-bit single-word and 32-bit two-word (opcode + immediate) instructions.
- Loads the IF/ID pipeline register consumed by decode, honouring stall and flush from the hazard/branch logic.

Parameters:
- ADDR_W, 12, instruction-memory word-address width; IMEM depth = 2^ADDR_W.
- LONG_BIT, 15, bit of the first word that marks a two-word instruction (1 = immediate follows).
- NOP_WORD, 16'h0000, instruction word emitted for bubbles.

Ports:
- clk  input  1  clock; all state updates on posedge (PC updates on negedge, so PC is stable at posedge).
- reset  input  1  synchronous, active-high.
- pc  input  32  current PC from the PC block.
- imem_addr  output  ADDR_W  instruction-memory word address.
- imem_data  input  16  combinational read data for imem_addr.
- stall  input  1  hazard unit: hold IF/ID and the internal state.
- flush  input  1  taken branch / call / ret / interrupt: discard everything in fetch.
- ifid_instr  output  16  opcode word.
- ifid_imm  output  16  immediate word; 0 for single-word instructions.
- ifid_pc  output  32  PC of the opcode word.
- ifid_valid  output  1  IF/ID holds a real instruction.
- ifid_long  output  1  instruction is two-word.
- addr_err  output  1  pc[31:ADDR_W] nonzero in the current cycle (combinational).
- fetch_count  output  16  number of instructions delivered, saturating.

Behaviour:
- imem_addr = pc[ADDR_W-1:0], combinational, every cycle.
- If addr_err = 1, the fetched word is treated as NOP_WORD (single-word).
- Reset (sync, high):
  - ifid_instr = NOP_WORD; ifid_imm, ifid_pc, ifid_valid, ifid_long and fetch_count = 0.
  - FSM -> S_OP; held first-word and first-PC registers cleared.
  - Reset overrides flush and stall. Reset mid-way through a two-word fetch discards the partial instruction.
- FSM states: S_OP (expect opcode word), S_IMM (expect immediate word).
- Priority each posedge: reset > flush > stall > normal.
- Flush:
  - FSM -> S_OP; held word discarded.
  - ifid_valid = 0, ifid_instr = NOP_WORD, ifid_imm = 0, ifid_long = 0.
  - fetch_count unchanged.
- Stall: FSM, held registers, all ifid_* and fetch_count hold. The word presented that cycle is not consumed (PC is held upstream).
- Normal operation in S_OP, word w:
  - If w[LONG_BIT] = 0: load IF/ID with instr = w, imm = 0, pc = pc, long = 0, valid = 1; fetch_count += 1; stay in S_OP.
  - If w[LONG_BIT] = 1: latch w and pc into the hold registers; load an IF/ID bubble (valid = 0, NOP_WORD); go to S_IMM.
- Normal operation in S_IMM, word w:
  - Load IF/ID with instr = held word, imm = w, pc = held pc, long = 1, valid = 1; fetch_count += 1; go to S_OP.
  - w is never decoded as an opcode, whatever its LONG_BIT.
- Latency: a single-word instruction at PC p appears in IF/ID at the posedge after p is presented. A two-word instruction appears one cycle later, preceded by exactly one bubble.
- fetch_count saturates at 16'hFFFF; no wrap.
- Simultaneous stall and flush: flush wins.
- A flush in S_IMM drops the held opcode; its immediate is never emitted.
- PC jumps (e.g. to 0 for the interrupt vector) are always accompanied by a flush from upstream control; no PC-discontinuity detection inside this block.

Test Plan:
- Reset then single-word stream: IMEM[32] = 16'h1234, IMEM[33] = 16'h2001, pc 32 then 33 -> ifid = {1234, imm 0, pc 32, valid 1}, then {2001, pc 33}; fetch_count = 2.
- Two-word: IMEM[40] = 16'h8A05, IMEM[41] = 16'h00FF -> bubble cycle (valid 0), then ifid_instr = 8A05, imm = 00FF, pc = 40, long = 1; immediate word 16'hFFFF likewise not treated as opcode.
- Stall: assert stall 3 cycles after a valid single-word load -> ifid_* and fetch_count frozen. Stall in S_IMM -> held word preserved; release -> correct 32-bit instruction emitted.
- Flush:
  - Flush in S_IMM after 16'h8A05 -> valid 0, FSM in S_OP.
  - Next word 16'h0042 at pc 0 -> emitted as single-word, pc 0.
  - stall = flush = 1 simultaneously -> flush behaviour.
- Boundary: pc = 32'h0001_0020 -> addr_err = 1, NOP_WORD loaded, valid 1. Preload fetch_count to FFFE via 3 deliveries from a forced state -> stays at FFFF.
- Reset during S_IMM -> all outputs zero/NOP next cycle; held opcode never appears.

Source files
------------

// File: rtl/fetch_ifid_unit.sv
// Instruction-fetch stage: drives the IMEM address from the PC, assembles
// single-word and two-word (opcode + immediate) instructions, and loads the
// IF/ID pipeline register with stall/flush handling.
module fetch_ifid_unit #(
  parameter int          ADDR_W   = 12,
  parameter int          LONG_BIT = 15,
  parameter logic [15:0] NOP_WORD = 16'h0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_data,
  input  logic              stall,
  input  logic              flush,
  output logic [15:0]       ifid_instr,
  output logic [15:0]       ifid_imm,
  output logic [31:0]       ifid_pc,
  output logic              ifid_valid,
  output logic              ifid_long,
  output logic              addr_err,
  output logic [15:0]       fetch_count
);

  typedef enum logic {S_OP, S_IMM} state_t;

  state_t      state_q, state_d;
  logic [15:0] hold_word_q, hold_word_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [15:0] ifid_instr_q, ifid_instr_d;
  logic [15:0] ifid_imm_q, ifid_imm_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        ifid_long_q, ifid_long_d;
  logic [15:0] fetch_count_q, fetch_count_d;
  logic [15:0] word;
  logic [15:0] count_inc;

  // Address decode: out-of-range PCs fetch a NOP instead of aliasing into IMEM.
  always_comb begin
    imem_addr = pc[ADDR_W-1:0];
    addr_err  = |pc[31:ADDR_W];
    word      = addr_err ? NOP_WORD : imem_data;
    count_inc = (fetch_count_q == 16'hFFFF) ? fetch_count_q : fetch_count_q + 16'd1;
  end

  // Next-state logic; priority is reset, then flush, then stall, then normal fetch.
  always_comb begin
    state_d       = state_q;
    hold_word_d   = hold_word_q;
    hold_pc_d     = hold_pc_q;
    ifid_instr_d  = ifid_instr_q;
    ifid_imm_d    = ifid_imm_q;
    ifid_pc_d     = ifid_pc_q;
    ifid_valid_d  = ifid_valid_q;
    ifid_long_d   = ifid_long_q;
    fetch_count_d = fetch_count_q;

    if (reset) begin
      state_d       = S_OP;
      hold_word_d   = 16'h0000;
      hold_pc_d     = 32'h0;
      ifid_instr_d  = NOP_WORD;
      ifid_imm_d    = 16'h0000;
      ifid_pc_d     = 32'h0;
      ifid_valid_d  = 1'b0;
      ifid_long_d   = 1'b0;
      fetch_count_d = 16'h0000;
    end else if (flush) begin
      state_d      = S_OP;
      hold_word_d  = 16'h0000;
      hold_pc_d    = 32'h0;
      ifid_instr_d = NOP_WORD;
      ifid_imm_d   = 16'h0000;
      ifid_valid_d = 1'b0;
      ifid_long_d  = 1'b0;
    end else if (!stall) begin
      case (state_q)
        S_OP: begin
          if (word[LONG_BIT]) begin
            hold_word_d  = word;
            hold_pc_d    = pc;
            ifid_instr_d = NOP_WORD;
            ifid_imm_d   = 16'h0000;
            ifid_valid_d = 1'b0;
            ifid_long_d  = 1'b0;
            state_d      = S_IMM;
          end else begin
            ifid_instr_d  = word;
            ifid_imm_d    = 16'h0000;
            ifid_pc_d     = pc;
            ifid_valid_d  = 1'b1;
            ifid_long_d   = 1'b0;
            fetch_count_d = count_inc;
          end
        end
        S_IMM: begin
          ifid_instr_d  = hold_word_q;
          ifid_imm_d    = word;
          ifid_pc_d     = hold_pc_q;
          ifid_valid_d  = 1'b1;
          ifid_long_d   = 1'b1;
          fetch_count_d = count_inc;
          state_d       = S_OP;
        end
        default: state_d = S_OP;
      endcase
    end
  end

  // State and IF/ID register update.
  always_ff @(posedge clk) begin
    state_q       <= state_d;
    hold_word_q   <= hold_word_d;
    hold_pc_q     <= hold_pc_d;
    ifid_instr_q  <= ifid_instr_d;
    ifid_imm_q    <= ifid_imm_d;
    ifid_pc_q     <= ifid_pc_d;
    ifid_valid_q  <= ifid_valid_d;
    ifid_long_q   <= ifid_long_d;
    fetch_count_q <= fetch_count_d;
  end

  assign ifid_instr  = ifid_instr_q;
  assign ifid_imm    = ifid_imm_q;
  assign ifid_pc     = ifid_pc_q;
  assign ifid_valid  = ifid_valid_q;
  assign ifid_long   = ifid_long_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_ifid_unit.sv
// Directed testbench for fetch_ifid_unit with a behavioural instruction memory.
module tb_fetch_ifid_unit;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic [11:0] imem_addr;
  logic [15:0] imem_data;
  logic        stall;
  logic        flush;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_imm;
  logic [31:0] ifid_pc;
  logic        ifid_valid;
  logic        ifid_long;
  logic        addr_err;
  logic [15:0] fetch_count;

  logic [15:0] imem [0:4095];
  int checks;
  int passes;

  fetch_ifid_unit dut (
    .clk(clk), .reset(reset), .pc(pc), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .flush(flush), .ifid_instr(ifid_instr), .ifid_imm(ifid_imm),
    .ifid_pc(ifid_pc), .ifid_valid(ifid_valid), .ifid_long(ifid_long),
    .addr_err(addr_err), .fetch_count(fetch_count)
  );

  assign imem_data = imem[imem_addr];

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: inputs change on the negedge, outputs sampled 1 time unit after the posedge.
  task automatic step(input logic [31:0] p, input logic s, input logic f, input logic r);
    @(negedge clk);
    pc = p; stall = s; flush = f; reset = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(32'd5, 1'b1, 1'b1, 1'b1);
    checks++; if (ifid_instr !== 16'h0000) $display("[TB] FAIL reset_instr got %h want 0000", ifid_instr); else passes++;
    checks++; if (ifid_imm !== 16'h0000) $display("[TB] FAIL reset_imm got %h want 0000", ifid_imm); else passes++;
    checks++; if (ifid_pc !== 32'h0) $display("[TB] FAIL reset_pc got %h want 0", ifid_pc); else passes++;
    checks++; if (ifid_valid !== 1'b0) $display("[TB] FAIL reset_valid got %b want 0", ifid_valid); else passes++;
    checks++; if (ifid_long !== 1'b0) $display("[TB] FAIL reset_long got %b want 0", ifid_long); else passes++;
    checks++; if (fetch_count !== 16'h0) $display("[TB] FAIL reset_count got %h want 0", fetch_count); else passes++;
  endtask

  task automatic test_single_word();
    step(32'd32, 1'b0, 1'b0, 1'b0);
    checks++; if (ifid_instr !== 16'h1234) $display("[TB] FAIL sw1_instr got %h want 1234", ifid_instr); else passes++;
    checks++; if (ifid_imm !== 16'h0000) $display("[TB] FAIL sw1_imm got %h want 0000", ifid_imm); else passes++;
    checks++; if (ifid_pc !== 32'd32) $display("[TB] FAIL sw1_pc got %0d want 32", ifid_pc); else passes++;
    checks++; if (ifid_valid !== 1'b1) $display("[TB] FAIL sw1_valid got %b want 1", ifid_valid); else passes++;
    checks++; if (ifid_long !== 1'b0) $display("[TB] FAIL sw1_long got %b want 0", ifid_long); else passes++;
    step(32'd33, 1'b0, 1'b0, 1'b0);
    checks++; if (ifid_instr !== 16'h2001) $display("[TB] FAIL sw2_instr got %h want 2001", ifid_instr); else passes++;
    checks++; if (ifid_pc !== 32'd33) $display("[TB] FAIL sw2_pc got %0d want 33", ifid_pc); else passes++;
    checks++; if (fetch_count !== 16'd2) $display("[TB] FAIL sw_count got %0d want 2", fetch_count); else passes++;
  endtask

  task automatic test_two_word();
    step(32'd40, 1'b0, 1'b0, 1'b0);
    checks++; if (ifid_valid !== 1'b0) $display("[TB] FAIL tw_bubble_valid got %b want 0", ifid_valid); else passes++;
    checks++; if (ifid_instr !== 16'h0000) $display("[TB] FAIL tw_bubble_instr got %h want 0000", ifid_instr); else passes++;
    step(32'd41, 1'b0, 1'b0, 1'b0);
    checks++; if (ifid_instr !== 16'h8A05) $display("[TB] FAIL tw_instr got %h want 8a05", ifid_instr); else passes++;
    checks++; if (ifid_imm !== 16'h00FF) $display("[TB] FAIL tw_imm got %h want 00ff", ifid_imm); else passes++;
    checks++; if (ifid_pc !== 32'd40) $display("[TB] FAIL tw_pc got %0d want 40", ifid_pc); else passes++;
    checks++; if (ifid_long !== 1'b1) $display("[TB] FAIL tw_long got %b want 1", ifid_long); else passes++;
    checks++; if (ifid_valid !== 1'b1) $display("[TB] FAIL tw_valid got %b want 1", ifid_valid); else passes++;
    checks++; if (fetch_count !== 16'd3) $display("[TB] FAIL tw_count got %0d want 3", fetch_count); else passes++;
    // Immediate with its long bit set must not be taken as an opcode.
    step(32'd50, 1'b0, 1'b0, 1'b0);
    step(32'd51, 1'b0, 1'b0, 1'b0);
    checks++; if (ifid_instr !== 16'h8123) $display("[TB] FAIL twf_instr got %h want 8123", ifid_instr); else passes++;
    checks++; if (ifid_imm !== 16'hFFFF) $display("[TB] FAIL twf_imm got %h want ffff", ifid_imm); else passes++;
    step(32'd52, 1'b0, 1'b0, 1'b0);
    checks++; if (ifid_instr !== 16'h0007) $display("[TB] FAIL twf_next_instr got %h want 0007", ifid_instr); else passes++;
    checks++; if (ifid_long !== 1'b0) $display("[TB] FAIL twf_next_long got %b want 0", ifid_long); else passes++;
    checks++; if (fetch_count !== 16'd5) $display("[TB] FAIL twf_count got %0d want 5", fetch_count); else passes++;
  endtask

  task automatic test_stall();
    step(32'd60, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(32'd61, 1'b1, 1'b0, 1'b0);
      checks++; if (ifid_instr !== 16'h3333) $display("[TB] FAIL stall%0d_instr got %h want 3333", i, ifid_instr); else passes++;
      checks++; if (ifid_pc !== 32'd60) $display("[TB] FAIL stall%0d_pc got %0d want 60", i, ifid_pc); else passes++;
      checks++; if (fetch_count !== 16'd6) $display("[TB] FAIL stall%0d_count got %0d want 6", i, fetch_count); else passes++;
    end
    step(32'd62, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(32'd63, 1'b1, 1'b0, 1'b0);
      checks++; if (ifid_valid !== 1'b0) $display("[TB] FAIL stall_imm%0d_valid got %b want 0", i, ifid_valid); else passes++;
    end
    step(32'd63, 1'b0, 1'b0, 1'b0);
    checks++; if (ifid_instr !== 16'h9ABC) $display("[TB] FAIL stall_rel_instr got %h want 9abc", ifid_instr); else passes++;
    checks++; if (ifid_imm !== 16'h5555) $display("[TB] FAIL stall_rel_imm got %h want 5555", ifid_imm); else passes++;
    checks++; if (ifid_pc !== 32'd62) $display("[TB] FAIL stall_rel_pc got %0d want 62", ifid_pc); else passes++;
    checks++; if (ifid_long !== 1'b1) $display("[TB] FAIL stall_rel_long got %b want 1", ifid_long); else passes++;
    checks++; if (fetch_count !== 16'd7) $display("[TB] FAIL stall_rel_count got %0d want 7", fetch_count); else passes++;
  endtask

  task automatic test_flush();
    step(32'd40, 1'b0, 1'b0, 1'b0);
    step(32'd41, 1'b0, 1'b1, 1'b0);
    checks++; if (ifid_valid !== 1'b0) $display("[TB] FAIL flush_valid got %b want 0", ifid_valid); else passes++;
    checks++; if (ifid_instr !== 16'h0000) $display("[TB] FAIL flush_instr got %h want 0000", ifid_instr); else passes++;
    checks++; if (ifid_imm !== 16'h0000) $display("[TB] FAIL flush_imm got %h want 0000", ifid_imm); else passes++;
    checks++; if (fetch_count !== 16'd7) $display("[TB] FAIL flush_count got %0d want 7", fetch_count); else passes++;
    step(32'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (ifid_instr !== 16'h0042) $display("[TB] FAIL flush_next_instr got %h want 0042", ifid_instr); else passes++;
    checks++; if (ifid_pc !== 32'd0) $display("[TB] FAIL flush_next_pc got %0d want 0", ifid_pc); else passes++;
    checks++; if (ifid_long !== 1'b0) $display("[TB] FAIL flush_next_long got %b want 0", ifid_long); else passes++;
    checks++; if (ifid_valid !== 1'b1) $display("[TB] FAIL flush_next_valid got %b want 1", ifid_valid); else passes++;
    // Stall and flush together: flush must win and return the FSM to S_OP.
    step(32'd40, 1'b0, 1'b0, 1'b0);
    step(32'd41, 1'b1, 1'b1, 1'b0);
    checks++; if (ifid_valid !== 1'b0) $display("[TB] FAIL sf_valid got %b want 0", ifid_valid); else passes++;
    step(32'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (ifid_instr !== 16'h0042) $display("[TB] FAIL sf_next_instr got %h want 0042", ifid_instr); else passes++;
    checks++; if (ifid_long !== 1'b0) $display("[TB] FAIL sf_next_long got %b want 0", ifid_long); else passes++;
    checks++; if (fetch_count !== 16'd9) $display("[TB] FAIL sf_count got %0d want 9", fetch_count); else passes++;
  endtask

  task automatic test_addr_err();
    @(negedge clk);
    pc = 32'd32; stall = 1'b0; flush = 1'b0; reset = 1'b0;
    #1;
    checks++; if (addr_err !== 1'b0) $display("[TB] FAIL aerr_low got %b want 0", addr_err); else passes++;
    pc = 32'h0001_0020;
    #1;
    checks++; if (addr_err !== 1'b1) $display("[TB] FAIL aerr_high got %b want 1", addr_err); else passes++;
    checks++; if (imem_addr !== 12'h020) $display("[TB] FAIL aerr_addr got %h want 020", imem_addr); else passes++;
    @(posedge clk);
    #1;
    checks++; if (ifid_instr !== 16'h0000) $display("[TB] FAIL aerr_instr got %h want 0000", ifid_instr); else passes++;
    checks++; if (ifid_valid !== 1'b1) $display("[TB] FAIL aerr_valid got %b want 1", ifid_valid); else passes++;
    checks++; if (ifid_pc !== 32'h0001_0020) $display("[TB] FAIL aerr_pc got %h want 00010020", ifid_pc); else passes++;
  endtask

  task automatic test_saturation();
    @(negedge clk);
    force dut.fetch_count_q = 16'hFFFE;
    #1;
    release dut.fetch_count_q;
    for (int i = 0; i < 3; i++) begin
      step(32'd32, 1'b0, 1'b0, 1'b0);
      checks++; if (fetch_count !== 16'hFFFF) $display("[TB] FAIL sat%0d_count got %h want ffff", i, fetch_count); else passes++;
    end
  endtask

  task automatic test_reset_mid();
    step(32'd40, 1'b0, 1'b0, 1'b0);
    step(32'd41, 1'b1, 1'b1, 1'b1);
    checks++; if (ifid_instr !== 16'h0000) $display("[TB] FAIL rmid_instr got %h want 0000", ifid_instr); else passes++;
    checks++; if (ifid_valid !== 1'b0) $display("[TB] FAIL rmid_valid got %b want 0", ifid_valid); else passes++;
    checks++; if (fetch_count !== 16'h0) $display("[TB] FAIL rmid_count got %h want 0", fetch_count); else passes++;
    step(32'd33, 1'b0, 1'b0, 1'b0);
    checks++; if (ifid_instr !== 16'h2001) $display("[TB] FAIL rmid_next_instr got %h want 2001", ifid_instr); else passes++;
    checks++; if (ifid_long !== 1'b0) $display("[TB] FAIL rmid_next_long got %b want 0", ifid_long); else passes++;
    checks++; if (fetch_count !== 16'd1) $display("[TB] FAIL rmid_next_count got %0d want 1", fetch_count); else passes++;
  endtask

  // Test sequence.
  initial begin
    checks = 0;
    passes = 0;
    reset = 1'b1; stall = 1'b0; flush = 1'b0; pc = 32'h0;
    for (int i = 0; i < 4096; i++) imem[i] = 16'h0000;
    imem[0]  = 16'h0042;
    imem[32] = 16'h1234;
    imem[33] = 16'h2001;
    imem[40] = 16'h8A05;
    imem[41] = 16'h00FF;
    imem[50] = 16'h8123;
    imem[51] = 16'hFFFF;
    imem[52] = 16'h0007;
    imem[60] = 16'h3333;
    imem[61] = 16'h4444;
    imem[62] = 16'h9ABC;
    imem[63] = 16'h5555;

    test_reset();
    test_single_word();
    test_two_word();
    test_stall();
    test_flush();
    test_addr_err();
    test_saturation();
    test_reset_mid();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
